// File: rtl/fifo_pattern_checker.sv
// -----------------------------------------------------------------------------
// fifo_pattern_checker
//
// Read-side checker for the asymmetric-width FIFO test path. The write side
// pushes an incrementing 16-bit count that the FIFO packs into 32-bit words
// {N, N+1}. This block drains the FIFO read port and verifies that every word
// continues the sequence {N+2, N+3}, ... (all arithmetic mod 2^16).
//
// Parameters:
//   THROTTLE       idle cycles inserted after each rd_en pulse (0 = back-to-back)
//   ERR_CNT_WIDTH  width of the saturating mismatch counter
//   WORD_CNT_WIDTH width of the wrapping checked-word counter
//
// Ports:
//   led_clk         in   checker clock, also the FIFO read clock
//   sys_rst         in   asynchronous, active-high reset
//   enable          in   level-sensitive permission to issue reads
//   fifo_empty      in   FIFO empty flag
//   fifo_rst_busy   in   FIFO reset in progress; blocks read issue
//   rd_en           out  registered FIFO read enable
//   rdata           in   FIFO read data, qualified by rd_valid
//   rd_valid        in   read data qualifier (any latency after rd_en)
//   locked          out  first consistent word seen, sequence tracked
//   error_flag      out  sticky: at least one mismatch since reset
//   err_count       out  mismatch count, saturates at all-ones
//   word_count      out  valid words processed, wraps
//   first_err_data  out  rdata of the first mismatch
//   first_err_exp   out  expected word at the first mismatch
// -----------------------------------------------------------------------------
module fifo_pattern_checker #(
  parameter int THROTTLE       = 0,
  parameter int ERR_CNT_WIDTH  = 16,
  parameter int WORD_CNT_WIDTH = 32
) (
  input  logic                      led_clk,
  input  logic                      sys_rst,
  input  logic                      enable,
  input  logic                      fifo_empty,
  input  logic                      fifo_rst_busy,
  output logic                      rd_en,
  input  logic [31:0]               rdata,
  input  logic                      rd_valid,
  output logic                      locked,
  output logic                      error_flag,
  output logic [ERR_CNT_WIDTH-1:0]  err_count,
  output logic [WORD_CNT_WIDTH-1:0] word_count,
  output logic [31:0]               first_err_data,
  output logic [31:0]               first_err_exp
);

  localparam int THR_W = (THROTTLE > 0) ? $clog2(THROTTLE + 1) : 1;

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } state_e;

  state_e                    state_q;
  logic [15:0]               exp_q;
  logic [THR_W-1:0]          thr_q, thr_d;
  logic                      rd_en_q, rd_en_d;
  logic                      locked_q, error_flag_q;
  logic [ERR_CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic [WORD_CNT_WIDTH-1:0] word_count_q;
  logic [31:0]               first_err_data_q, first_err_exp_q;

  logic [15:0] data_hi, data_lo;
  logic [31:0] exp_word, err_exp_word;
  logic        seed_ok, mismatch;

  // NOTE: every signal assigned in always_comb gets a default on entry, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_en_d      = 1'b0;
    thr_d        = thr_q;
    err_count_d  = err_count_q;
    data_hi      = rdata[31:16];
    data_lo      = rdata[15:0];
    seed_ok      = (data_lo == data_hi + 16'd1);
    exp_word     = {exp_q, exp_q + 16'd1};
    err_exp_word = exp_word;
    mismatch     = 1'b0;

    // Read issue: one pulse per throttle period while the FIFO can serve it.
    if (enable && !fifo_empty && !fifo_rst_busy && (thr_q == '0)) begin
      rd_en_d = 1'b1;
      thr_d   = THR_W'(THROTTLE);
    end else if (thr_q != '0) begin
      thr_d = thr_q - THR_W'(1);
    end

    // In SEED the word is judged against itself; in CHECK against exp.
    if (state_q == SEED) begin
      mismatch     = rd_valid && !seed_ok;
      err_exp_word = {data_hi, data_hi + 16'd1};
    end else begin
      mismatch     = rd_valid && (rdata != exp_word);
    end

    if (err_count_q != '1) begin
      err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q          <= SEED;
      exp_q            <= '0;
      thr_q            <= '0;
      rd_en_q          <= 1'b0;
      locked_q         <= 1'b0;
      error_flag_q     <= 1'b0;
      err_count_q      <= '0;
      word_count_q     <= '0;
      first_err_data_q <= '0;
      first_err_exp_q  <= '0;
    end else begin
      rd_en_q <= rd_en_d;
      thr_q   <= thr_d;

      if (rd_valid) begin
        word_count_q <= word_count_q + WORD_CNT_WIDTH'(1);

        // On a CHECK match data_hi equals exp_q, so this single update both
        // advances the sequence and resyncs after a mismatch. In SEED it only
        // matters when the seed is accepted.
        exp_q <= data_hi + 16'd2;

        case (state_q)
          SEED: begin
            if (seed_ok) begin
              state_q  <= CHECK;
              locked_q <= 1'b1;
            end
          end
          CHECK: begin
            locked_q <= 1'b1;
          end
          default: state_q <= SEED;
        endcase

        if (mismatch) begin
          error_flag_q <= 1'b1;
          err_count_q  <= err_count_d;
          // Capture only the first mismatch; it is held until reset,
          // independent of counter saturation.
          if (!error_flag_q) begin
            first_err_data_q <= rdata;
            first_err_exp_q  <= err_exp_word;
          end
        end
      end
    end
  end

  assign rd_en          = rd_en_q;
  assign locked         = locked_q;
  assign error_flag     = error_flag_q;
  assign err_count      = err_count_q;
  assign word_count     = word_count_q;
  assign first_err_data = first_err_data_q;
  assign first_err_exp  = first_err_exp_q;

endmodule

// File: tb/tb_fifo_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_fifo_pattern_checker
//
// Directed bench for fifo_pattern_checker. Instance "a" uses default
// parameters; instance "b" uses THROTTLE=3 and a 2-bit error counter for the
// throttle and saturation scenarios. Both see the same stimulus.
// -----------------------------------------------------------------------------
module tb_fifo_pattern_checker;

  logic        led_clk = 1'b0;
  logic        sys_rst;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_rst_busy;
  logic [31:0] rdata;
  logic        rd_valid;

  logic        a_rd_en, a_locked, a_error_flag;
  logic [15:0] a_err_count;
  logic [31:0] a_word_count, a_first_err_data, a_first_err_exp;

  logic        b_rd_en, b_locked, b_error_flag;
  logic [1:0]  b_err_count;
  logic [31:0] b_word_count, b_first_err_data, b_first_err_exp;

  int n_vec = 0;
  int n_err = 0;

  fifo_pattern_checker u_dut_a (
    .led_clk        (led_clk),
    .sys_rst        (sys_rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_rst_busy  (fifo_rst_busy),
    .rd_en          (a_rd_en),
    .rdata          (rdata),
    .rd_valid       (rd_valid),
    .locked         (a_locked),
    .error_flag     (a_error_flag),
    .err_count      (a_err_count),
    .word_count     (a_word_count),
    .first_err_data (a_first_err_data),
    .first_err_exp  (a_first_err_exp)
  );

  fifo_pattern_checker #(
    .THROTTLE       (3),
    .ERR_CNT_WIDTH  (2),
    .WORD_CNT_WIDTH (32)
  ) u_dut_b (
    .led_clk        (led_clk),
    .sys_rst        (sys_rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_rst_busy  (fifo_rst_busy),
    .rd_en          (b_rd_en),
    .rdata          (rdata),
    .rd_valid       (rd_valid),
    .locked         (b_locked),
    .error_flag     (b_error_flag),
    .err_count      (b_err_count),
    .word_count     (b_word_count),
    .first_err_data (b_first_err_data),
    .first_err_exp  (b_first_err_exp)
  );

  always #5 led_clk = ~led_clk;

  // Present one word for one clock; outputs are sampled 1 ns after the edge.
  task automatic send(input logic [31:0] w);
    rd_valid = 1'b1;
    rdata    = w;
    @(posedge led_clk);
    #1;
    rd_valid = 1'b0;
    rdata    = '0;
  endtask

  // Reset pulse placed mid-cycle, away from any clock edge.
  task automatic pulse_reset();
    sys_rst = 1'b1;
    #2;
    sys_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_rst_busy = 1'b0;
    rd_valid = 1'b0; rdata = '0;
    #1;
    n_vec++; if (a_locked !== 1'b0 || a_error_flag !== 1'b0 || a_rd_en !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got locked=%b err=%b rd_en=%b want 0 0 0", a_locked, a_error_flag, a_rd_en); end
    n_vec++; if (a_err_count !== 16'd0 || a_word_count !== 32'd0) begin
      n_err++; $display("FAIL reset_counts: got err=%0d words=%0d want 0 0", a_err_count, a_word_count); end
    n_vec++; if (a_first_err_data !== 32'd0 || a_first_err_exp !== 32'd0) begin
      n_err++; $display("FAIL reset_capture: got %h %h want 0 0", a_first_err_data, a_first_err_exp); end
    repeat (2) @(posedge led_clk);
    #1;
    n_vec++; if (b_locked !== 1'b0 || b_err_count !== 2'd0 || b_rd_en !== 1'b0) begin
      n_err++; $display("FAIL reset_held_b: got locked=%b err=%0d rd_en=%b want 0 0 0", b_locked, b_err_count, b_rd_en); end
    sys_rst = 1'b0;
    @(posedge led_clk);
    #1;
  endtask

  task automatic test_clean_stream();
    pulse_reset();
    for (int i = 0; i < 1000; i++) begin
      send({16'(2 * i), 16'(2 * i + 1)});
      if (i == 0) begin
        n_vec++; if (a_locked !== 1'b1) begin
          n_err++; $display("FAIL clean_locked_after_w0: got %b want 1", a_locked); end
      end
    end
    n_vec++; if (a_error_flag !== 1'b0 || a_err_count !== 16'd0) begin
      n_err++; $display("FAIL clean_no_error: got flag=%b count=%0d want 0 0", a_error_flag, a_err_count); end
    n_vec++; if (a_word_count !== 32'd1000) begin
      n_err++; $display("FAIL clean_word_count: got %0d want 1000", a_word_count); end
  endtask

  task automatic test_wrap();
    pulse_reset();
    send(32'hFFFC_FFFD);
    send(32'hFFFE_FFFF);
    // Word accepted while the FIFO reports reset-busy: still processed.
    fifo_rst_busy = 1'b1;
    send(32'h0000_0001);
    fifo_rst_busy = 1'b0;
    n_vec++; if (a_error_flag !== 1'b0 || a_locked !== 1'b1 || a_word_count !== 32'd3) begin
      n_err++; $display("FAIL wrap_fffe: got flag=%b locked=%b words=%0d want 0 1 3", a_error_flag, a_locked, a_word_count); end
    pulse_reset();
    send(32'hFFFF_0000);
    n_vec++; if (a_locked !== 1'b1 || a_error_flag !== 1'b0) begin
      n_err++; $display("FAIL wrap_seed_ffff: got locked=%b flag=%b want 1 0", a_locked, a_error_flag); end
    send(32'h0001_0002);
    n_vec++; if (a_err_count !== 16'd0 || a_word_count !== 32'd2) begin
      n_err++; $display("FAIL wrap_ffff_next: got err=%0d words=%0d want 0 2", a_err_count, a_word_count); end
  endtask

  task automatic test_drop();
    pulse_reset();
    send(32'h0010_0011);
    send(32'h0014_0015);
    n_vec++; if (a_err_count !== 16'd1 || a_error_flag !== 1'b1) begin
      n_err++; $display("FAIL drop_err: got count=%0d flag=%b want 1 1", a_err_count, a_error_flag); end
    n_vec++; if (a_first_err_data !== 32'h0014_0015) begin
      n_err++; $display("FAIL drop_cap_data: got %h want 00140015", a_first_err_data); end
    n_vec++; if (a_first_err_exp !== 32'h0012_0013) begin
      n_err++; $display("FAIL drop_cap_exp: got %h want 00120013", a_first_err_exp); end
    send(32'h0016_0017);
    n_vec++; if (a_err_count !== 16'd1 || a_word_count !== 32'd3 || a_locked !== 1'b1) begin
      n_err++; $display("FAIL drop_resync: got err=%0d words=%0d locked=%b want 1 3 1", a_err_count, a_word_count, a_locked); end
  endtask

  task automatic test_bad_seed();
    pulse_reset();
    send(32'h0005_0007);
    n_vec++; if (a_err_count !== 16'd1 || a_locked !== 1'b0) begin
      n_err++; $display("FAIL badseed_first: got err=%0d locked=%b want 1 0", a_err_count, a_locked); end
    n_vec++; if (a_first_err_data !== 32'h0005_0007 || a_first_err_exp !== 32'h0005_0006) begin
      n_err++; $display("FAIL badseed_capture: got %h %h want 00050007 00050006", a_first_err_data, a_first_err_exp); end
    send(32'h0008_0009);
    n_vec++; if (a_err_count !== 16'd1 || a_locked !== 1'b1) begin
      n_err++; $display("FAIL badseed_lock: got err=%0d locked=%b want 1 1", a_err_count, a_locked); end
    send(32'h000A_000B);
    n_vec++; if (a_err_count !== 16'd1 || a_word_count !== 32'd3) begin
      n_err++; $display("FAIL badseed_track: got err=%0d words=%0d want 1 3", a_err_count, a_word_count); end
  endtask

  task automatic test_saturation();
    pulse_reset();
    send(32'h0005_0007);
    send(32'h0009_0000);
    send(32'h0011_0000);
    n_vec++; if (b_err_count !== 2'd3) begin
      n_err++; $display("FAIL sat_reach: got %0d want 3", b_err_count); end
    send(32'h0013_0000);
    n_vec++; if (b_err_count !== 2'd3 || a_err_count !== 16'd4) begin
      n_err++; $display("FAIL sat_hold: got b=%0d a=%0d want 3 4", b_err_count, a_err_count); end
    n_vec++; if (b_first_err_data !== 32'h0005_0007 || b_first_err_exp !== 32'h0005_0006) begin
      n_err++; $display("FAIL sat_capture_held: got %h %h want 00050007 00050006", b_first_err_data, b_first_err_exp); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    send(32'h0010_0011);
    send(32'h0050_0051);
    send(32'h0070_0071);
    send(32'h0090_0091);
    n_vec++; if (a_err_count !== 16'd3 || a_locked !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: got err=%0d locked=%b want 3 1", a_err_count, a_locked); end
    sys_rst = 1'b1;
    #1;
    n_vec++; if (a_locked !== 1'b0 || a_error_flag !== 1'b0 || a_err_count !== 16'd0 || a_word_count !== 32'd0) begin
      n_err++; $display("FAIL rstmid_async: got locked=%b flag=%b err=%0d words=%0d want 0 0 0 0", a_locked, a_error_flag, a_err_count, a_word_count); end
    n_vec++; if (a_first_err_data !== 32'd0 || a_first_err_exp !== 32'd0) begin
      n_err++; $display("FAIL rstmid_capture: got %h %h want 0 0", a_first_err_data, a_first_err_exp); end
    #1;
    sys_rst = 1'b0;
    send(32'h0020_0021);
    n_vec++; if (a_locked !== 1'b1 || a_err_count !== 16'd0 || a_word_count !== 32'd1) begin
      n_err++; $display("FAIL rstmid_reseed: got locked=%b err=%0d words=%0d want 1 0 1", a_locked, a_err_count, a_word_count); end
  endtask

  task automatic test_throttle();
    pulse_reset();
    enable     = 1'b1;
    fifo_empty = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge led_clk);
      #1;
      n_vec++; if (b_rd_en !== ((c % 4) == 0) || a_rd_en !== 1'b1) begin
        n_err++; $display("FAIL throttle_cycle%0d: got b=%b a=%b want %b 1", c, b_rd_en, a_rd_en, ((c % 4) == 0)); end
    end
    fifo_empty = 1'b1;
    @(posedge led_clk);
    #1;
    n_vec++; if (a_rd_en !== 1'b0 || b_rd_en !== 1'b0) begin
      n_err++; $display("FAIL throttle_empty: got a=%b b=%b want 0 0", a_rd_en, b_rd_en); end
    fifo_empty    = 1'b0;
    fifo_rst_busy = 1'b1;
    repeat (2) @(posedge led_clk);
    #1;
    n_vec++; if (a_rd_en !== 1'b0 || b_rd_en !== 1'b0) begin
      n_err++; $display("FAIL throttle_rst_busy: got a=%b b=%b want 0 0", a_rd_en, b_rd_en); end
    fifo_rst_busy = 1'b0;
    enable        = 1'b0;
    @(posedge led_clk);
    #1;
    n_vec++; if (a_rd_en !== 1'b0 || b_rd_en !== 1'b0) begin
      n_err++; $display("FAIL throttle_disabled: got a=%b b=%b want 0 0", a_rd_en, b_rd_en); end
    enable = 1'b1;
    @(posedge led_clk);
    #1;
    n_vec++; if (a_rd_en !== 1'b1 || b_rd_en !== 1'b1) begin
      n_err++; $display("FAIL throttle_resume: got a=%b b=%b want 1 1", a_rd_en, b_rd_en); end
    enable     = 1'b0;
    fifo_empty = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_stream();
    test_wrap();
    test_drop();
    test_bad_seed();
    test_saturation();
    test_reset_mid();
    test_throttle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
